fp_writeback_arbiter: RTL and testbench

FP_WRITEBACK_ARBITER -- requirements
Module: fp_writeback_arbiter

---
 rtl/cva5_types.sv | 20 ++
 rtl/fp_writeback_arbiter_pkg.sv | 15 +
 rtl/fp_wb_rr_select.sv | 42 ++++
 rtl/fp_writeback_arbiter.sv | 144 ++++++++++++++
 tb/tb_fp_writeback_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cva5_types.sv
`default_nettype none
// ============================================================================
// Package     : cva5_types
// Description : Shared floating-point writeback widths and packet type.
// Revision    : 1.0 - initial release
// ============================================================================
package cva5_types;

    localparam int FLEN         = 64;
    localparam int LOG2_MAX_IDS = 3;

    // One register-file write: data tagged with the producing instruction id.
    typedef struct packed {
        logic                    valid;
        logic [LOG2_MAX_IDS-1:0] id;
        logic [FLEN-1:0]         data;
    } fp_wb_packet_t;

endpackage
`default_nettype wire

// File: rtl/fp_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_writeback_arbiter_pkg
// Description : Helpers shared by the writeback arbiter and its selector.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_writeback_arbiter_pkg;

    // Width of an index into n sources; a single source still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_wb_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : fp_wb_rr_select
// Description : Finds the first set request bit at or after a start index,
//               wrapping around the vector.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_rr_select #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] start_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    // Position under test, one bit wider so start+k can exceed N before wrap.
    logic [PTR_W:0] w_pos;

    // Walk the vector in search order and keep the first hit.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        w_pos    = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, start_i} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(N)) begin
                w_pos = w_pos - (PTR_W+1)'(N);
            end
            if (!found_o && req_i[w_pos[PTR_W-1:0]]) begin
                found_o                     = 1'b1;
                idx_o                       = w_pos[PTR_W-1:0];
                onehot_o[w_pos[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_writeback_arbiter
// Description : Round-robin arbiter granting up to NUM_WB_PORTS of NUM_UNITS
//               FP result sources onto register-file write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_writeback_arbiter
    import cva5_types::*;
    import fp_writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS         = 4,
    parameter int NUM_WB_PORTS      = 2,
    parameter int REGISTERED_OUTPUT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_UNITS-1:0]    unit_done_i,
    input  logic [LOG2_MAX_IDS-1:0] unit_id_i [NUM_UNITS],
    input  logic [FLEN-1:0]         unit_rd_i [NUM_UNITS],
    output logic [NUM_UNITS-1:0]    unit_ack_o,
    output fp_wb_packet_t           wb_packet_o [NUM_WB_PORTS]
);

    localparam int PTR_W = ptr_width(NUM_UNITS);

    logic [PTR_W-1:0]                   rr_ptr_q;
    logic [PTR_W-1:0]                   rr_ptr_d;
    // Requests are masked during reset so no ack can escape while rst is high.
    logic [NUM_UNITS-1:0]               w_req;
    logic [NUM_UNITS-1:0]               w_grant;
    logic [NUM_WB_PORTS-1:0]            w_port_valid;
    logic [NUM_WB_PORTS-1:0][PTR_W-1:0] w_port_idx;
    logic                               w_any_grant;
    logic [PTR_W-1:0]                   w_last_idx;
    fp_wb_packet_t                      w_pkt [NUM_WB_PORTS];

    assign w_req      = rst ? '0 : unit_done_i;
    assign unit_ack_o = w_grant;

    if (NUM_WB_PORTS == NUM_UNITS) begin : g_direct
        // Every unit owns a port, so there is nothing to arbitrate.
        assign w_grant     = w_req;
        assign w_any_grant = 1'b0;
        assign w_last_idx  = '0;
        for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_map
            assign w_port_valid[p] = w_req[p];
            assign w_port_idx[p]   = PTR_W'(p);
        end
    end else begin : g_rr
        logic [NUM_WB_PORTS-1:0][NUM_UNITS-1:0] w_stage_req;
        logic [NUM_WB_PORTS-1:0][NUM_UNITS-1:0] w_stage_oh;

        // Each stage sees the requests left over after all earlier stages.
        for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_stage
            if (p == 0) begin : g_first
                assign w_stage_req[p] = w_req;
            end else begin : g_next
                assign w_stage_req[p] = w_stage_req[p-1] & ~w_stage_oh[p-1];
            end

            fp_wb_rr_select #(
                .N     (NUM_UNITS),
                .PTR_W (PTR_W)
            ) u_select (
                .req_i    (w_stage_req[p]),
                .start_i  (rr_ptr_q),
                .found_o  (w_port_valid[p]),
                .idx_o    (w_port_idx[p]),
                .onehot_o (w_stage_oh[p])
            );
        end

        // Merge per-stage grants and find the last unit granted in search order.
        always_comb begin
            w_grant     = '0;
            w_any_grant = 1'b0;
            w_last_idx  = '0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                w_grant = w_grant | w_stage_oh[p];
                if (w_port_valid[p]) begin
                    w_any_grant = 1'b1;
                    w_last_idx  = w_port_idx[p];
                end
            end
        end
    end

    // Resume the search just past the last unit served this cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_any_grant) begin
            if (w_last_idx == PTR_W'(NUM_UNITS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_last_idx + PTR_W'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Steer each granted unit's id and data onto its port.
    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            w_pkt[p] = '0;
            if (w_port_valid[p]) begin
                w_pkt[p].valid = 1'b1;
                w_pkt[p].id    = unit_id_i[w_port_idx[p]];
                w_pkt[p].data  = unit_rd_i[w_port_idx[p]];
            end
        end
    end

    if (REGISTERED_OUTPUT != 0) begin : g_out_reg
        fp_wb_packet_t wb_packet_q [NUM_WB_PORTS];

        // Output stage; reset drops any packet not yet written back.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int p = 0; p < NUM_WB_PORTS; p++) begin
                    wb_packet_q[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NUM_WB_PORTS; p++) begin
                    wb_packet_q[p] <= w_pkt[p];
                end
            end
        end

        assign wb_packet_o = wb_packet_q;
    end else begin : g_out_comb
        assign wb_packet_o = w_pkt;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_writeback_arbiter
// Description : Self-checking bench for fp_writeback_arbiter (registered,
//               combinational and direct-mapped configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_writeback_arbiter;
    import cva5_types::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              done;
    logic [LOG2_MAX_IDS-1:0] ids [4];
    logic [FLEN-1:0]         rds [4];
    logic [LOG2_MAX_IDS-1:0] ids_d [2];
    logic [FLEN-1:0]         rds_d [2];
    logic [3:0]              ack_r;
    logic [3:0]              ack_c;
    logic [1:0]              ack_d;
    fp_wb_packet_t           pk_r [2];
    fp_wb_packet_t           pk_c [2];
    fp_wb_packet_t           pk_d [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ids_d[0] = ids[0];
    assign ids_d[1] = ids[1];
    assign rds_d[0] = rds[0];
    assign rds_d[1] = rds[1];

    fp_writeback_arbiter #(.NUM_UNITS(4), .NUM_WB_PORTS(2), .REGISTERED_OUTPUT(1)) dut (
        .clk(clk), .rst(rst), .unit_done_i(done), .unit_id_i(ids), .unit_rd_i(rds),
        .unit_ack_o(ack_r), .wb_packet_o(pk_r));

    fp_writeback_arbiter #(.NUM_UNITS(4), .NUM_WB_PORTS(2), .REGISTERED_OUTPUT(0)) dut_comb (
        .clk(clk), .rst(rst), .unit_done_i(done), .unit_id_i(ids), .unit_rd_i(rds),
        .unit_ack_o(ack_c), .wb_packet_o(pk_c));

    fp_writeback_arbiter #(.NUM_UNITS(2), .NUM_WB_PORTS(2), .REGISTERED_OUTPUT(1)) dut_direct (
        .clk(clk), .rst(rst), .unit_done_i(done[1:0]), .unit_id_i(ids_d), .unit_rd_i(rds_d),
        .unit_ack_o(ack_d), .wb_packet_o(pk_d));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input fp_wb_packet_t p, input logic v,
                           input logic [LOG2_MAX_IDS-1:0] id, input logic [FLEN-1:0] data);
        chk({name, ".valid"}, 64'(p.valid), 64'(v));
        if (v) begin
            chk({name, ".id"}, 64'(p.id), 64'(id));
            chk({name, ".data"}, p.data, data);
        end
    endtask

    typedef struct {
        logic [3:0] done;
        logic [3:0] ack;
        logic       v0;
        int         u0;
        logic       v1;
        int         u1;
    } vec_t;

    vec_t vecs [14];

    // Random-phase state
    int              rr_m;
    int              port [2];
    int              nport;
    logic [3:0]      exp_ack;
    logic [3:0]      prev_ack;
    int              waitc [4];
    int              acked;
    int              written;
    logic            sv [2];
    logic [2:0]      sid [2];
    logic [63:0]     sdat [2];
    logic            dv [2];
    logic [2:0]      did [2];
    logic [63:0]     ddat [2];

    initial begin
        // done, ack, port0 valid/unit, port1 valid/unit; rr starts at 0 after reset
        vecs[0]  = '{4'hF, 4'h3, 1'b1, 0, 1'b1, 1};
        vecs[1]  = '{4'hF, 4'hC, 1'b1, 2, 1'b1, 3};
        vecs[2]  = '{4'hF, 4'h3, 1'b1, 0, 1'b1, 1};
        vecs[3]  = '{4'hF, 4'hC, 1'b1, 2, 1'b1, 3};
        vecs[4]  = '{4'h8, 4'h8, 1'b1, 3, 1'b0, 0};
        vecs[5]  = '{4'h0, 4'h0, 1'b0, 0, 1'b0, 0};
        vecs[6]  = '{4'h4, 4'h4, 1'b1, 2, 1'b0, 0};
        vecs[7]  = '{4'h9, 4'h9, 1'b1, 3, 1'b1, 0};
        vecs[8]  = '{4'h6, 4'h6, 1'b1, 1, 1'b1, 2};
        vecs[9]  = '{4'h7, 4'h3, 1'b1, 0, 1'b1, 1};
        vecs[10] = '{4'h5, 4'h5, 1'b1, 2, 1'b1, 0};
        vecs[11] = '{4'hA, 4'hA, 1'b1, 1, 1'b1, 3};
        vecs[12] = '{4'h1, 4'h1, 1'b1, 0, 1'b0, 0};
        vecs[13] = '{4'hF, 4'h6, 1'b1, 1, 1'b1, 2};

        ids[0] = 3'd1; rds[0] = 64'h0000_0000_0000_00A0;
        ids[1] = 3'd2; rds[1] = 64'h0000_0000_0000_00A1;
        ids[2] = 3'd3; rds[2] = 64'h0000_0000_0000_00A2;
        ids[3] = 3'd5; rds[3] = 64'h3FF0_0000_0000_0000;

        // Reset with every unit requesting
        rst  = 1'b1;
        done = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_reg", 64'(ack_r), 64'h0);
        chk("rst_ack_comb", 64'(ack_c), 64'h0);
        chk("rst_ack_direct", 64'(ack_d), 64'h0);
        for (int p = 0; p < 2; p++) begin
            chk("rst_valid_reg", 64'(pk_r[p].valid), 64'h0);
            chk("rst_valid_comb", 64'(pk_c[p].valid), 64'h0);
            chk("rst_valid_direct", 64'(pk_d[p].valid), 64'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            done = vecs[i].done;
            @(negedge clk);
            chk($sformatf("vec%0d_ack_reg", i), 64'(ack_r), 64'(vecs[i].ack));
            chk($sformatf("vec%0d_ack_comb", i), 64'(ack_c), 64'(vecs[i].ack));
            chk($sformatf("vec%0d_ack_direct", i), 64'(ack_d), 64'(vecs[i].done[1:0]));
            chk_pkt($sformatf("vec%0d_comb_p0", i), pk_c[0], vecs[i].v0, ids[vecs[i].u0], rds[vecs[i].u0]);
            chk_pkt($sformatf("vec%0d_comb_p1", i), pk_c[1], vecs[i].v1, ids[vecs[i].u1], rds[vecs[i].u1]);
            @(posedge clk);
            #1;
            chk_pkt($sformatf("vec%0d_reg_p0", i), pk_r[0], vecs[i].v0, ids[vecs[i].u0], rds[vecs[i].u0]);
            chk_pkt($sformatf("vec%0d_reg_p1", i), pk_r[1], vecs[i].v1, ids[vecs[i].u1], rds[vecs[i].u1]);
            chk_pkt($sformatf("vec%0d_direct_p0", i), pk_d[0], vecs[i].done[0], ids[0], rds[0]);
            chk_pkt($sformatf("vec%0d_direct_p1", i), pk_d[1], vecs[i].done[1], ids[1], rds[1]);
        end

        // Grant unit 0 (pointer is at 3), then reset right after the capture edge
        done = 4'h1;
        @(negedge clk);
        chk("preflush_ack", 64'(ack_r), 64'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        done = 4'hF;
        #1;
        chk("flush_valid_p0", 64'(pk_r[0].valid), 64'h0);
        chk("flush_valid_p1", 64'(pk_r[1].valid), 64'h0);
        @(negedge clk);
        chk("flush_ack_in_rst", 64'(ack_r), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("flush_valid_after", 64'(pk_r[0].valid | pk_r[1].valid), 64'h0);
        @(negedge clk);
        chk("post_rst_ack", 64'(ack_r), 64'h3);
        @(posedge clk);
        #1;
        chk_pkt("post_rst_p0", pk_r[0], 1'b1, ids[0], rds[0]);
        chk_pkt("post_rst_p1", pk_r[1], 1'b1, ids[1], rds[1]);

        // Random traffic against a round-robin reference model
        rst  = 1'b1;
        done = 4'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        rr_m     = 0;
        prev_ack = 4'h0;
        acked    = 0;
        written  = 0;
        for (int u = 0; u < 4; u++) waitc[u] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int u = 0; u < 4; u++) begin
                if (prev_ack[u] || !done[u]) begin
                    done[u] = ($urandom_range(0, 3) != 0);
                    ids[u]  = 3'($urandom);
                    rds[u]  = {$urandom, $urandom};
                end
            end
            @(negedge clk);
            exp_ack = 4'h0;
            nport   = 0;
            port[0] = 0;
            port[1] = 0;
            for (int k = 0; k < 4; k++) begin
                if (done[(rr_m + k) % 4] && nport < 2) begin
                    port[nport] = (rr_m + k) % 4;
                    exp_ack[(rr_m + k) % 4] = 1'b1;
                    nport++;
                end
            end
            if (nport > 0) rr_m = (port[nport-1] + 1) % 4;
            chk("rand_ack_reg", 64'(ack_r), 64'(exp_ack));
            chk("rand_ack_comb", 64'(ack_c), 64'(exp_ack));
            chk("rand_ack_direct", 64'(ack_d), 64'(done[1:0]));
            for (int p = 0; p < 2; p++) begin
                chk_pkt("rand_comb", pk_c[p], p < nport, ids[port[p]], rds[port[p]]);
                sv[p]   = (p < nport);
                sid[p]  = ids[port[p]];
                sdat[p] = rds[port[p]];
                dv[p]   = done[p];
                did[p]  = ids[p];
                ddat[p] = rds[p];
            end
            for (int u = 0; u < 4; u++) begin
                if (done[u] && !ack_r[u]) waitc[u]++;
                else                      waitc[u] = 0;
                chk("rand_starvation", 64'(waitc[u]), (waitc[u] > 1) ? 64'd1 : 64'(waitc[u]));
            end
            acked   += $countones(ack_r);
            prev_ack = ack_r;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                chk_pkt("rand_reg", pk_r[p], sv[p], sid[p], sdat[p]);
                chk_pkt("rand_direct", pk_d[p], dv[p], did[p], ddat[p]);
                written += int'(pk_r[p].valid);
            end
        end
        chk("rand_written_total", 64'(written), 64'(acked));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
